// File: rtl/fiber_bank_requester.sv
// Request-side engine for one fiber cache bank: a single-entry request register,
// credit-based admission of data-returning commands, an in-order response FIFO and a drain/flush FSM.
module fiber_bank_requester #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned RESP_DEPTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [3:0]            i_cmd_type,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic [3:0]            o_request_type,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_i_valid,
  input  logic                  i_data_i_ready,
  input  logic [DATA_WIDTH-1:0] i_data_o,
  input  logic                  i_data_o_valid,
  output logic                  o_data_o_ready,
  output logic [DATA_WIDTH-1:0] o_resp_data,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  input  logic                  i_flush,
  output logic                  o_flush_done,
  output logic                  o_err_illegal
);
  localparam int unsigned PtrW = $clog2(RESP_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth = CntW'(RESP_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StFlush} state_e;

  state_e                state_q;
  logic                  live_q, flush_pending_q, flush_done_q, err_q, req_valid_q;
  logic [3:0]            req_type_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_data_q;
  logic [CntW-1:0]       outstanding_q, outstanding_d, count_q, count_d, credits;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];

  logic cmd_legal, cmd_is_data, entry_is_data, credit_ok, cmd_ready;
  logic cmd_accept, cmd_load, bank_hs, resp_push, resp_drop, resp_pop;

  assign cmd_legal     = $onehot(i_cmd_type);
  assign cmd_is_data   = cmd_legal && (i_cmd_type[1] || i_cmd_type[3]);
  assign entry_is_data = req_valid_q && (req_type_q[1] || req_type_q[3]);
  assign bank_hs       = req_valid_q && i_data_i_ready;
  assign resp_push     = i_data_o_valid && live_q && (outstanding_q != '0);
  assign resp_drop     = i_data_o_valid && live_q && (outstanding_q == '0);
  assign resp_pop      = (count_q != '0) && i_resp_ready;

  // A data command held in the entry has already claimed one credit.
  assign credits   = Depth - outstanding_q - count_q;
  assign credit_ok = !cmd_is_data || (credits > {{(CntW-1){1'b0}}, entry_is_data});

  always_comb begin
    cmd_ready = 1'b0;
    case (state_q)
      StIdle:  cmd_ready = live_q && !i_flush && credit_ok;
      StIssue: cmd_ready = i_data_i_ready && !flush_pending_q && credit_ok;
      default: cmd_ready = 1'b0;
    endcase
  end

  assign cmd_accept    = i_cmd_valid && cmd_ready;
  assign cmd_load      = cmd_accept && cmd_legal;
  assign outstanding_d = outstanding_q + CntW'(bank_hs && entry_is_data) - CntW'(resp_push);
  assign count_d       = count_q + CntW'(resp_push) - CntW'(resp_pop);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q         <= StIdle;
      live_q          <= 1'b0;
      flush_pending_q <= 1'b0;
      flush_done_q    <= 1'b0;
      err_q           <= 1'b0;
      req_valid_q     <= 1'b0;
      req_type_q      <= '0;
      req_addr_q      <= '0;
      req_data_q      <= '0;
    end else begin
      live_q       <= 1'b1;
      flush_done_q <= 1'b0;
      if ((cmd_accept && !cmd_legal) || resp_drop) err_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (i_flush) begin
            state_q <= StFlush;
          end else if (cmd_load) begin
            state_q     <= StIssue;
            req_valid_q <= 1'b1;
            req_type_q  <= i_cmd_type;
            req_addr_q  <= i_cmd_addr;
            req_data_q  <= i_cmd_data;
          end
        end
        StIssue: begin
          if (i_flush) flush_pending_q <= 1'b1;
          if (bank_hs) begin
            if (cmd_load) begin
              req_type_q <= i_cmd_type;
              req_addr_q <= i_cmd_addr;
              req_data_q <= i_cmd_data;
            end else begin
              req_valid_q     <= 1'b0;
              flush_pending_q <= 1'b0;
              state_q         <= (flush_pending_q || i_flush) ? StFlush : StIdle;
            end
          end
        end
        StFlush: begin
          // Judge on post-edge counts so the pulse lands the cycle right after the last pop.
          if (outstanding_d == '0 && count_d == '0) begin
            flush_done_q <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      if (resp_push) begin
        mem_q[wr_ptr_q] <= i_data_o;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (resp_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  assign o_cmd_ready    = cmd_ready;
  assign o_request_type = req_type_q;
  assign o_addr         = req_addr_q;
  assign o_data         = req_data_q;
  assign o_data_i_valid = req_valid_q;
  assign o_data_o_ready = live_q;
  assign o_resp_valid   = (count_q != '0);
  assign o_resp_data    = mem_q[rd_ptr_q];
  assign o_flush_done   = flush_done_q;
  assign o_err_illegal  = err_q;

endmodule

// File: tb/tb_fiber_bank_requester.sv
// Directed bench for fiber_bank_requester: reset, stalled write, illegal command, credits,
// FETCH/CONSUME streaming and flush.
module tb_fiber_bank_requester;
  localparam logic [3:0] Fetch = 4'b0001, Read = 4'b0010, Write = 4'b0100, Consume = 4'b1000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_type = '0;
  logic [63:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic [3:0]  req_type;
  logic [63:0] req_addr;
  logic [15:0] req_data;
  logic        req_valid, bank_ready = 1'b0;
  logic [15:0] bank_data;
  logic        bank_valid, data_o_ready;
  logic [15:0] resp_data;
  logic        resp_valid, resp_ready = 1'b0, flush = 1'b0, flush_done, err;

  logic        bank_auto = 1'b0, auto_valid = 1'b0, man_valid = 1'b0;
  logic [15:0] auto_data = '0, auto_seq = '0, man_data = '0;
  int          checks = 0, errors = 0;
  int          hs_cnt = 0, acc_cnt = 0, pop_cnt = 0, fd_cnt = 0;

  assign bank_valid = bank_auto ? auto_valid : man_valid;
  assign bank_data  = bank_auto ? auto_data : man_data;

  fiber_bank_requester dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_type(cmd_type),
    .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
    .o_request_type(req_type), .o_addr(req_addr), .o_data(req_data),
    .o_data_i_valid(req_valid), .i_data_i_ready(bank_ready),
    .i_data_o(bank_data), .i_data_o_valid(bank_valid), .o_data_o_ready(data_o_ready),
    .o_resp_data(resp_data), .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .i_flush(flush), .o_flush_done(flush_done), .o_err_illegal(err)
  );

  always #5 clk = ~clk;

  // Bank model: returns an incrementing word one cycle after each READ/CONSUME handshake.
  always @(posedge clk) begin
    auto_valid <= 1'b0;
    if (bank_auto && req_valid && bank_ready && (req_type == Read || req_type == Consume)) begin
      auto_valid <= 1'b1;
      auto_data  <= auto_seq + 16'd1;
      auto_seq   <= auto_seq + 16'd1;
    end
  end

  always @(posedge clk) begin
    if (req_valid && bank_ready) hs_cnt <= hs_cnt + 1;
    if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    if (resp_valid && resp_ready) pop_cnt <= pop_cnt + 1;
    if (flush_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] t, input logic [63:0] a,
                       input logic [15:0] d);
    cmd_valid = v; cmd_type = t; cmd_addr = a; cmd_data = d;
  endtask

  task automatic test_reset();
    logic [150:0] outs;
    repeat (2) tick();
    outs = {req_type, req_addr, req_data, req_valid, data_o_ready, resp_data, resp_valid,
            flush_done, err, cmd_ready};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst = 1'b0;
    tick();
    // Build up a held WRITE entry and two FIFO entries, then reset mid-transfer.
    bank_ready = 1'b1;
    drive(1'b1, Read, 64'h1, '0); tick();
    drive(1'b1, Read, 64'h2, '0); tick();
    drive(1'b1, Write, 64'h3, 16'h5555); tick();
    drive(1'b0, Fetch, '0, '0); bank_ready = 1'b0;
    man_valid = 1'b1; man_data = 16'h0011; tick();
    man_data = 16'h0022; tick();
    man_valid = 1'b0;
    checks++;
    if ({resp_valid, req_valid, resp_data} !== {2'b11, 16'h0011}) begin
      errors++; $display("FAIL pre_reset_state: got %b%b %h want 11 0011", resp_valid, req_valid,
                         resp_data);
    end
    #2 rst = 1'b1;
    #1;
    outs = {req_type, req_addr, req_data, req_valid, data_o_ready, resp_data, resp_valid,
            flush_done, err, cmd_ready};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL async_reset: got %h want 0", outs); end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({cmd_ready, resp_valid, req_valid} !== 3'b100) begin
      errors++; $display("FAIL post_reset: rdy/rv/qv got %b%b%b want 100", cmd_ready,
                         resp_valid, req_valid);
    end
  endtask

  task automatic test_write_stall();
    int h0;
    drive(1'b1, Write, 64'h1230, 16'hBEEF); bank_ready = 1'b0;
    tick();
    drive(1'b0, Fetch, '0, '0);
    h0 = hs_cnt;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bank_ready = 1'b1;
      #1;
      checks++;
      if ({req_valid, req_type, req_addr, req_data} !== {1'b1, Write, 64'h1230, 16'hBEEF}) begin
        errors++; $display("FAIL write_hold[%0d]: got v=%b t=%b a=%h d=%h want 1 0100 1230 beef",
                           i, req_valid, req_type, req_addr, req_data);
      end
      tick();
    end
    bank_ready = 1'b0;
    checks++;
    if (hs_cnt - h0 !== 1) begin errors++; $display("FAIL write_hs_count: got %0d want 1", hs_cnt - h0); end
    checks++;
    if ({req_valid, resp_valid, cmd_ready} !== 3'b001) begin
      errors++; $display("FAIL write_idle: qv/rv/rdy got %b%b%b want 001", req_valid, resp_valid,
                         cmd_ready);
    end
  endtask

  task automatic test_illegal();
    int h0 = hs_cnt;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_initial: got %b want 0", err); end
    drive(1'b1, 4'b0110, 64'h77, 16'h1); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b want 1", cmd_ready); end
    tick();
    drive(1'b0, Fetch, '0, '0);
    checks++;
    if ({err, req_valid} !== 2'b10) begin
      errors++; $display("FAIL illegal_drop: err/qv got %b%b want 10", err, req_valid);
    end
    repeat (3) tick();
    checks++;
    if ({err, hs_cnt - h0} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL illegal_sticky: err=%b hs=%0d want 1 0", err, hs_cnt - h0);
    end
  endtask

  task automatic test_credits();
    int a0 = acc_cnt, h0 = hs_cnt;
    bank_auto = 1'b1; bank_ready = 1'b1; resp_ready = 1'b0;
    drive(1'b1, Read, 64'h40, '0);
    repeat (16) tick();
    checks++;
    if (acc_cnt - a0 !== 8) begin errors++; $display("FAIL credit_accepts: got %0d want 8", acc_cnt - a0); end
    checks++;
    if (hs_cnt - h0 !== 8) begin errors++; $display("FAIL credit_issued: got %0d want 8", hs_cnt - h0); end
    checks++;
    if ({cmd_ready, resp_valid, resp_data} !== {2'b01, 16'h0001}) begin
      errors++; $display("FAIL credit_full: rdy=%b rv=%b data=%h want 0 1 0001", cmd_ready,
                         resp_valid, resp_data);
    end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    repeat (5) tick();
    checks++;
    if ({acc_cnt - a0, cmd_ready} !== {32'd9, 1'b0}) begin
      errors++; $display("FAIL credit_refill: acc=%0d rdy=%b want 9 0", acc_cnt - a0, cmd_ready);
    end
    drive(1'b0, Fetch, '0, '0);
    resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({resp_valid, resp_data} !== {1'b1, 16'(k + 2)}) begin
        errors++; $display("FAIL resp_order[%0d]: got v=%b %h want 1 %h", k, resp_valid,
                           resp_data, 16'(k + 2));
      end
      tick();
    end
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_empty: got %b want 0", resp_valid); end
  endtask

  task automatic test_fetch_consume();
    logic [3:0] types [5] = '{Fetch, Consume, Fetch, Consume, Consume};
    int         exp_out [5] = '{0, 0, 1, 0, 1};
    int         h0 = hs_cnt, p0 = pop_cnt;
    bank_auto = 1'b1; bank_ready = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, types[i], 64'(i), '0); #1;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL fc_ready[%0d]: got %b want 1", i, cmd_ready); end
      tick();
      checks++;
      if (int'(dut.outstanding_q) !== exp_out[i]) begin
        errors++; $display("FAIL fc_outstanding[%0d]: got %0d want %0d", i, dut.outstanding_q,
                           exp_out[i]);
      end
    end
    drive(1'b0, Fetch, '0, '0);
    tick();
    checks++;
    if (int'(dut.outstanding_q) !== 1) begin
      errors++; $display("FAIL fc_issue_and_return: got %0d want 1", dut.outstanding_q);
    end
    repeat (3) tick();
    checks++;
    if ({hs_cnt - h0, pop_cnt - p0} !== {32'd5, 32'd3}) begin
      errors++; $display("FAIL fc_counts: hs=%0d pops=%0d want 5 3", hs_cnt - h0, pop_cnt - p0);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_flush();
    int fd0;
    bank_auto = 1'b1; bank_ready = 1'b1; resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, Read, 64'(i), '0); #1;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL flush_setup[%0d]: got %b want 1", i, cmd_ready); end
      tick();
    end
    drive(1'b0, Fetch, '0, '0); bank_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; bank_ready = 1'b1; drive(1'b1, Fetch, '0, '0); #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL flush_pending_ready: got %b want 0", cmd_ready); end
    tick();
    drive(1'b0, Fetch, '0, '0);
    repeat (3) tick();
    checks++;
    if ({cmd_ready, flush_done, resp_valid} !== 3'b001) begin
      errors++; $display("FAIL flush_wait: rdy/done/rv got %b%b%b want 001", cmd_ready,
                         flush_done, resp_valid);
    end
    fd0 = fd_cnt;
    flush = 1'b1; resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({resp_data, flush_done, cmd_ready} !== {16'(13 + k), 2'b00}) begin
        errors++; $display("FAIL flush_drain[%0d]: data=%h done=%b rdy=%b want %h 0 0", k,
                           resp_data, flush_done, cmd_ready, 16'(13 + k));
      end
      tick();
      flush = 1'b0;
    end
    resp_ready = 1'b0;
    checks++;
    if (flush_done !== 1'b1) begin errors++; $display("FAIL flush_done_pulse: got %b want 1", flush_done); end
    tick();
    checks++;
    if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_done_width: got %b want 0", flush_done); end
    repeat (3) tick();
    checks++;
    if ({fd_cnt - fd0, cmd_ready} !== {32'd1, 1'b1}) begin
      errors++; $display("FAIL flush_single: pulses=%0d rdy=%b want 1 1", fd_cnt - fd0, cmd_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_stall();
    test_illegal();
    test_credits();
    test_fetch_consume();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fiber_bank_requester.md
Name: fiber_bank_requester

Overview:
- Initiator-side engine that drives the request port of one fiber cache bank on behalf of a processing element.
- Accepts FETCH/READ/WRITE/CONSUME commands from the PE and issues them to the bank with valid/ready.
- Uses credits so that every data-returning request is guaranteed a slot in an in-order response FIFO.
- Supports a flush that drains all in-flight traffic and reports completion.

Parameters:
- DATA_WIDTH, 16, width of bank data words.
- ADDR_WIDTH, 64, width of the bank address.
- RESP_DEPTH, 8, response FIFO entries; also the credit pool for data-returning requests (power of 2, at least 2).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  PE command valid.
- o_cmd_ready  out  1  command accepted when valid && ready.
- i_cmd_type  in  4  one-hot: 0001 FETCH, 0010 READ, 0100 WRITE, 1000 CONSUME.
- i_cmd_addr  in  ADDR_WIDTH  command address.
- i_cmd_data  in  DATA_WIDTH  write data; used only for WRITE.
- o_request_type  out  4  one-hot type to bank.
- o_addr  out  ADDR_WIDTH  address to bank.
- o_data  out  DATA_WIDTH  write data to bank.
- o_data_i_valid  out  1  request valid to bank.
- i_data_i_ready  in  1  bank accepts request.
- i_data_o  in  DATA_WIDTH  bank read data.
- i_data_o_valid  in  1  bank read data valid.
- o_data_o_ready  out  1  ready for bank read data.
- o_resp_data  out  DATA_WIDTH  response to PE, in issue order.
- o_resp_valid  out  1  response valid.
- i_resp_ready  in  1  PE accepts response.
- i_flush  in  1  single-cycle pulse requesting a drain.
- o_flush_done  out  1  one-cycle pulse when the drain is complete.
- o_err_illegal  out  1  sticky; set on a non-one-hot command. Cleared only by reset.

Behaviour:
- Reset values: all outputs 0; state IDLE; outstanding=0; FIFO empty. Reset mid-transfer abandons the request and all FIFO contents.
- Request register: a single entry holding type, addr and data.
  - o_data_i_valid=1 iff the entry is full.
  - Contents stay stable while valid && !ready.
  - No combinational path from i_cmd_* to o_request_type/o_addr/o_data/o_data_i_valid.
- Data-returning requests: READ and CONSUME return data. FETCH and WRITE return nothing.
- Credits: credits = RESP_DEPTH - outstanding - fifo_count.
  - A READ/CONSUME command is accepted only if credits - (entry holds READ/CONSUME ? 1 : 0) > 0.
  - outstanding increments on bank handshake of a READ/CONSUME request.
  - outstanding decrements when i_data_o_valid && o_data_o_ready.
  - All counter updates in the same cycle are summed; no event is dropped.
- o_data_o_ready: 1 in every state after reset. The credit scheme guarantees FIFO space. Data arriving while outstanding==0 is dropped and sets o_err_illegal.
- FSM:
  - IDLE (entry empty). o_cmd_ready=!flushing && credit check.
    - Legal command accepted -> entry loaded -> ISSUE.
    - Illegal command (zero or more than one bit set) is accepted and dropped, o_err_illegal set, stays in IDLE.
    - i_flush -> FLUSH.
  - ISSUE (entry full).
    - o_cmd_ready=1 only when i_data_i_ready=1 and the credit check passes, so back-to-back commands issue at 1 per cycle.
    - Handshake with no new command -> IDLE.
    - Handshake with a new command -> entry reloaded, stays in ISSUE.
    - i_flush is latched into a flush_pending flag, and o_cmd_ready is forced to 0 from the next cycle. After the handshake the FSM goes to FLUSH.
  - FLUSH. o_cmd_ready=0.
    - Waits for outstanding==0 && FIFO empty.
    - Then pulses o_flush_done for 1 cycle -> IDLE.
    - i_flush received while already in FLUSH is ignored.
- Response FIFO: depth RESP_DEPTH, circular pointers wrapping modulo RESP_DEPTH, count width clog2(RESP_DEPTH)+1.
  - o_resp_valid = !empty. o_resp_data = head entry (registered storage, show-ahead).
  - Push and pop in the same cycle leave the count unchanged. This includes the empty case: a push into an empty FIFO becomes visible the next cycle, so there is no fall-through.
- Latency: command accepted at cycle N -> o_data_i_valid at N+1. Bank data at cycle M -> o_resp_valid at M+1.

Test Plan:
- Reset asserted mid-ISSUE with an entry held and 2 FIFO entries -> all outputs 0 next edge; after release o_cmd_ready=1 and o_resp_valid=0.
- WRITE addr=0x1230 data=0xBEEF, bank ready held 0 for 3 cycles then 1 -> o_addr/o_data stable for 4 cycles, single handshake, no response, state back to IDLE.
- 10 back-to-back READs with i_resp_ready=0 and the bank returning data 0x0001..0x0008 -> exactly 8 issued (credits exhausted) and o_cmd_ready=0. Popping one response admits exactly one more READ. Responses come out in order 0x0001, 0x0002, ...
- Alternating FETCH/CONSUME, bank always ready -> 1 request per cycle. outstanding counts only CONSUMEs. A simultaneous issue and return leaves outstanding unchanged.
- i_cmd_type=0110 -> command dropped, o_err_illegal=1 and stays set, no bank request issued.
- i_flush with 3 reads outstanding -> o_cmd_ready=0 until done. o_flush_done pulses once, exactly 1 cycle after the last response pop. A second i_flush during FLUSH produces no extra pulse.
